// File: rtl/error_recovery_unit.sv
// Serial error-recovery stage for an approximate adder tree: adds the shifted
// dropped-carry vector back onto the approximate product one slice per cycle.
module error_recovery_unit #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_approx,
    input  logic [DATA_W-1:0]       in_err,
    input  logic                    in_recover,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_result,
    output logic                    out_ovf,
    output logic [$clog2(DATA_W):0] out_nerr
);
    localparam int NS = DATA_W / SLICE_W;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;
    localparam int NW = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] a_reg, e_reg, res, res_next;
    logic [CW-1:0]     k;
    logic              carry, pend_ovf, c_out;
    logic [NW-1:0]     nerr_reg, in_cnt;
    logic [SLICE_W-1:0] sum_sl;

    function automatic logic [NW-1:0] popcount(input logic [DATA_W-1:0] v);
        logic [NW-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_W; i++) c = c + NW'(v[i]);
        return c;
    endfunction

    // Operands are shifted down each cycle so the active slice is always at the bottom;
    // the result fills in from the top and is only exposed once complete.
    always_comb begin
        {c_out, sum_sl} = {1'b0, a_reg[SLICE_W-1:0]} + {1'b0, e_reg[SLICE_W-1:0]}
                        + (SLICE_W+1)'(carry);
        res_next = (res >> SLICE_W) | (DATA_W'(sum_sl) << (DATA_W - SLICE_W));
        in_cnt   = popcount(in_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_ovf    <= 1'b0;
            out_nerr   <= '0;
            a_reg      <= '0;
            e_reg      <= '0;
            res        <= '0;
            k          <= '0;
            carry      <= 1'b0;
            pend_ovf   <= 1'b0;
            nerr_reg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        pend_ovf <= in_err[DATA_W-1];
                        nerr_reg <= in_cnt;
                        if (in_recover) begin
                            a_reg <= in_approx;
                            e_reg <= in_err << 1;
                            res   <= '0;
                            k     <= '0;
                            carry <= 1'b0;
                            state <= ADD;
                        end else begin
                            out_result <= in_approx;
                            out_ovf    <= 1'b0;
                            out_nerr   <= in_cnt;
                            out_valid  <= 1'b1;
                            state      <= DONE;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ADD: begin
                    a_reg <= a_reg >> SLICE_W;
                    e_reg <= e_reg >> SLICE_W;
                    carry <= c_out;
                    res   <= res_next;
                    k     <= k + 1'b1;
                    if (k == CW'(NS - 1)) begin
                        out_result <= res_next;
                        out_ovf    <= c_out | pend_ovf;
                        out_nerr   <= nerr_reg;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
